// File: rtl/piso_tx.sv
// Parallel-to-serial transmitter: one-word holding register in front of a shifter,
// one bit per clock on ser_d/ser_en, word_done pulse after each word, optional idle gap.
module piso_tx #(
    parameter int WIDTH     = 4,
    parameter int GAP       = 0,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_d,
    output logic             ser_en,
    output logic             word_done,
    output logic             busy
);

    localparam int BW = $clog2(WIDTH);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] hold;
    logic             hold_full, hold_full_nx;
    logic [WIDTH-1:0] shreg, shreg_nx;
    logic [BW-1:0]    bit_cnt, bit_cnt_nx;
    logic [GW-1:0]    gap_cnt, gap_cnt_nx;
    logic             reload;
    logic             ser_en_nx, ser_d_nx, done_nx;

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] s);
        if (MSB_FIRST)
            return {s[WIDTH-2:0], 1'b0};
        else
            return {1'b0, s[WIDTH-1:1]};
    endfunction

    function automatic logic line_bit(input logic [WIDTH-1:0] s);
        return MSB_FIRST ? s[WIDTH-1] : s[0];
    endfunction

    assign in_ready = !hold_full && !rst;
    assign busy     = (state != S_IDLE) || hold_full;

    always_comb begin
        state_nx     = state;
        shreg_nx     = shreg;
        bit_cnt_nx   = bit_cnt;
        gap_cnt_nx   = gap_cnt;
        hold_full_nx = hold_full;
        done_nx      = 1'b0;
        reload       = 1'b0;

        case (state)
            S_IDLE: begin
                if (hold_full) begin
                    reload   = 1'b1;
                    state_nx = S_SHIFT;
                end
            end
            S_SHIFT: begin
                shreg_nx   = advance(shreg);
                bit_cnt_nx = bit_cnt + 1'b1;
                if (bit_cnt == BW'(WIDTH - 1)) begin
                    done_nx = 1'b1;
                    if (GAP == 0 && hold_full) begin
                        reload = 1'b1;
                    end else if (GAP > 0) begin
                        state_nx   = S_GAP;
                        gap_cnt_nx = '0;
                    end else begin
                        state_nx = S_IDLE;
                    end
                end
            end
            S_GAP: begin
                // word_done cycle is already the first gap cycle
                gap_cnt_nx = gap_cnt + 1'b1;
                if (gap_cnt == GW'(GAP - 1)) begin
                    if (hold_full) begin
                        reload   = 1'b1;
                        state_nx = S_SHIFT;
                    end else begin
                        state_nx = S_IDLE;
                    end
                end
            end
            default: state_nx = S_IDLE;
        endcase

        if (reload) begin
            shreg_nx     = hold;
            bit_cnt_nx   = '0;
            hold_full_nx = 1'b0;
        end
        if (in_valid && in_ready)
            hold_full_nx = 1'b1;

        ser_en_nx = (state_nx == S_SHIFT);
        ser_d_nx  = ser_en_nx && line_bit(shreg_nx);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            hold_full <= 1'b0;
            shreg     <= '0;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
            ser_en    <= 1'b0;
            ser_d     <= 1'b0;
            word_done <= 1'b0;
        end else begin
            state     <= state_nx;
            hold_full <= hold_full_nx;
            shreg     <= shreg_nx;
            bit_cnt   <= bit_cnt_nx;
            gap_cnt   <= gap_cnt_nx;
            ser_en    <= ser_en_nx;
            ser_d     <= ser_d_nx;
            word_done <= done_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (in_valid && in_ready)
            hold <= in_data;
    end

endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx: three configurations driven with directed and random words; each
// accepted word's bit timing comes from a start-time formula and feeds a scoreboard.
module tb_piso_tx;

    typedef struct {
        int   cyc;
        logic b;
    } bit_t;

    typedef struct {
        int a;
        int s;
    } rec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    bit done_f [3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d actual %0h required %0h", name, cyc, act, exp);
        end
    endtask

    for (genvar K = 0; K < 3; K++) begin : g
        localparam int W    = (K == 2) ? 5 : 4;
        localparam int G    = (K == 0) ? 0 : ((K == 1) ? 2 : 1);
        localparam bit M    = (K == 2) ? 1'b0 : 1'b1;
        localparam int NCYC = 2500;

        logic         rst      = 1'b1;
        logic         in_valid = 1'b0;
        logic [W-1:0] in_data  = '0;
        logic         in_ready, ser_d, ser_en, word_done, busy;

        bit_t bitq[$];
        int   doneq[$];
        rec_t recs[$];

        piso_tx #(.WIDTH(W), .GAP(G), .MSB_FIRST(M)) dut (
            .clk      (clk),
            .rst      (rst),
            .in_data  (in_data),
            .in_valid (in_valid),
            .in_ready (in_ready),
            .ser_d    (ser_d),
            .ser_en   (ser_en),
            .word_done(word_done),
            .busy     (busy)
        );

        initial begin : drv
            logic [W-1:0] src[$];
            logic [W-1:0] d;
            logic         rdy, rst_n, arm;
            int           rst_at, last_s, a, s;
            arm    = 1'b0;
            rst_at = -1;
            last_s = -100000;
            while (cyc < NCYC + 80) begin
                @(negedge clk);
                #1;
                if (cyc == 5) src.push_back(W'(4'b1011));
                if (cyc == 25) begin
                    src.push_back(W'(4'b1011));
                    src.push_back(W'(4'b0110));
                    src.push_back(W'(4'b1001));
                    src.push_back(W'(4'b1100));
                    src.push_back(W'(4'b0011));
                end
                if (cyc == 70) begin
                    src.push_back(W'(4'b1011));
                    arm = 1'b1;
                end
                if (cyc == 90) src.push_back(W'(4'b0101));
                if (cyc >= 110 && cyc < NCYC && src.size() < 2 && $urandom_range(0, 3) != 0)
                    src.push_back(W'($urandom));

                rst_n = (cyc < 2) || (cyc == rst_at) ||
                        (cyc >= 110 && cyc < NCYC && $urandom_range(0, 99) == 0);
                rst = rst_n;
                if (rst_n) begin
                    bitq.delete();
                    doneq.delete();
                    recs.delete();
                    last_s = -100000;
                end
                #1;
                rdy      = in_ready;
                in_valid = (src.size() > 0) &&
                           (cyc < 110 || cyc >= NCYC || $urandom_range(0, 3) != 0);
                if (src.size() > 0) in_data = src[0];
                if (in_valid && rdy) begin
                    d = src.pop_front();
                    a = cyc + 1;
                    s = (a + 1 > last_s + W + G) ? a + 1 : last_s + W + G;
                    for (int i = 0; i < W; i++)
                        bitq.push_back('{s + i, M ? d[W-1-i] : d[i]});
                    doneq.push_back(s + W);
                    recs.push_back('{a, s});
                    last_s = s;
                    if (arm) begin
                        rst_at = a + 2;
                        arm    = 1'b0;
                    end
                end
            end
            in_valid = 1'b0;
            chk($sformatf("g%0d.bits_left", K), bitq.size(), 0);
            chk($sformatf("g%0d.done_left", K), doneq.size(), 0);
            done_f[K] = 1'b1;
        end

        always @(negedge clk) begin : mon
            int   c;
            logic hf, bz, exp_v;
            if (cyc >= 1 && !done_f[K]) begin
                c = cyc;
                while (recs.size() > 0 && c >= recs[0].s + W + G) recs.delete(0);
                hf = 1'b0;
                bz = 1'b0;
                foreach (recs[i]) begin
                    if (recs[i].a <= c && c < recs[i].s) hf = 1'b1;
                    if (recs[i].a <= c) bz = 1'b1;
                end
                chk($sformatf("g%0d.in_ready", K), in_ready, !rst && !hf);
                chk($sformatf("g%0d.busy", K), busy, bz);

                if (ser_en === 1'b1) begin
                    if (bitq.size() == 0) begin
                        chk($sformatf("g%0d.ser_en_extra", K), ser_en, 1'b0);
                    end else begin
                        chk($sformatf("g%0d.ser_d", K), ser_d, bitq[0].b);
                        chk($sformatf("g%0d.bit_cycle", K), c, bitq[0].cyc);
                        bitq.delete(0);
                    end
                end else begin
                    exp_v = (bitq.size() > 0) && (bitq[0].cyc <= c);
                    chk($sformatf("g%0d.ser_en", K), ser_en, exp_v);
                    chk($sformatf("g%0d.ser_d_idle", K), ser_d, 1'b0);
                    if (exp_v) bitq.delete(0);
                end

                if (word_done === 1'b1) begin
                    if (doneq.size() == 0) begin
                        chk($sformatf("g%0d.done_extra", K), word_done, 1'b0);
                    end else begin
                        chk($sformatf("g%0d.done_cycle", K), c, doneq[0]);
                        doneq.delete(0);
                    end
                end else begin
                    exp_v = (doneq.size() > 0) && (doneq[0] <= c);
                    chk($sformatf("g%0d.word_done", K), word_done, exp_v);
                    if (exp_v) doneq.delete(0);
                end
            end
        end
    end

    initial begin
        logic all_done;
        all_done = 1'b0;
        while (!all_done && cyc < 4000) begin
            @(negedge clk);
            all_done = done_f[0] && done_f[1] && done_f[2];
        end
        chk("bench_complete", all_done, 1'b1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/piso_tx.md
Name: piso_tx

Overview:
- Parallel-to-serial transmitter that sits directly upstream of the serial-in/parallel-out stage.
- Accepts WIDTH-bit words over a valid/ready handshake and buffers one word in a holding register while the previous word is shifting.
- Emits one bit per clock on ser_d with a per-bit strobe ser_en, which drives the SIPO load/data inputs.
- Pulses word_done after the last bit of each word, which drives the SIPO shift/capture input.

Parameters:
- WIDTH, 4, bits per word (≥2).
- GAP, 0, idle cycles inserted after each word before the next word starts (0 = back-to-back).
- MSB_FIRST, 1, 1 = transmit bit WIDTH-1 first; 0 = transmit bit 0 first.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  parallel word to transmit.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  holding register empty; a word is accepted on an edge where in_valid && in_ready.
- ser_d  output  1  serial data bit (registered).
- ser_en  output  1  ser_d carries a valid bit this cycle (registered).
- word_done  output  1  one-cycle pulse after the last bit of a word (registered).
- busy  output  1  a word is held, shifting, or in its gap.

Behaviour:
- Reset:
  - clk and rst only; all state is synchronous to the rising edge of clk.
  - rst high at an edge clears hold_full, shifter, bit counter and gap counter, and sets state=IDLE.
  - After that edge: ser_d=0, ser_en=0, word_done=0, busy=0, in_ready=1.
  - in_ready is forced to 0 while rst is high. in_valid is ignored during rst.
- Handshake:
  - in_ready = !hold_full && !rst, combinational.
  - On accept, in_data is stored in the hold register. The caller may change in_data after the accepting edge.
- FSM states: IDLE, SHIFT, GAP.
  - IDLE: ser_en=0, ser_d=0. At an edge with hold_full, copy hold to the shifter, clear hold_full, set bit_cnt=0, go to SHIFT.
  - SHIFT: ser_en=1 and ser_d is the current bit, selected by MSB_FIRST. Each edge advances the shifter and increments bit_cnt.
  - At the edge ending bit WIDTH-1, word_done=1 for exactly the next cycle. Then:
    - if GAP=0 and hold_full: reload the shifter from hold, clear hold_full, stay in SHIFT. The next word's first bit is on the line in the same cycle as word_done.
    - else if GAP>0: go to GAP with gap_cnt=0.
    - else: go to IDLE.
  - GAP: ser_en=0, ser_d=0. After GAP cycles, go to SHIFT (reload from hold) if hold_full, otherwise go to IDLE.
  - The word_done cycle counts as the first GAP cycle.
- Latency:
  - Accept at edge E0.
  - bit0 is on ser_d in the cycle after E1 = E0+1; bit i in the cycle after E0+1+i.
  - word_done is high in the cycle after E0+1+WIDTH.
- Buffering:
  - The hold register empties at the reload edge, so in_ready rises one cycle later.
  - A new word may be accepted while the shifter is transmitting. Accept and reload can never coincide.
  - With in_valid held high, the sustained rate is one word per WIDTH+GAP cycles when GAP=0 or hold is refilled in time.
- busy = (state != IDLE) || hold_full.
- Reset mid-word: the partial word and the held word are discarded. No word_done is issued for them. The line is idle from the next cycle.
- Outputs never go X after the first reset. ser_d is 0 whenever ser_en is 0.

Test Plan:
1. WIDTH=4, MSB_FIRST=1: accept 4'b1011 at t0 -> ser_en high for 4 cycles starting the cycle after t0+1, ser_d=1,0,1,1. word_done high for 1 cycle after the 4th bit. Downstream SIPO q=1011.
2. Back-to-back, GAP=0: words 1011 then 0110, in_valid held high -> 8 contiguous ser_en cycles, ser_d=1,0,1,1,0,1,1,0. word_done pulses coincide with the first bit of word 2 and the cycle after bit 8. Exactly 2 accepts.
3. GAP=2: same two words -> 2 cycles of ser_en=0 between words (word_done cycle + 1), then 0,1,1,0.
4. Backpressure: in_valid held high with 3 words queued -> in_ready low while hold is full. No word lost or duplicated; output sequence matches input order.
5. Reset mid-word: rst asserted after 2 bits of 1011 -> ser_en=0, word_done=0, busy=0, in_ready=1 after the reset edge. The next accepted word 0101 is sent cleanly.
6. MSB_FIRST=0: accept 4'b1011 -> ser_d=1,1,0,1.
